// File: rtl/pulse_train_gen_if.sv
// Request/config and waveform/status bundle for pulse_train_gen.
// The requester holds master; the generator holds slave.
interface pulse_train_gen_if #(
  parameter int LEN_W = 8,
  parameter int NUM_W = 8
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             wave;
  logic             rise_edge;
  logic             fall_edge;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, high_len, low_len, num_pulses,
    input  wave, rise_edge, fall_edge, busy, done
  );

  modport slave (
    input  start, abort, high_len, low_len, num_pulses,
    output wave, rise_edge, fall_edge, busy, done
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Burst pulse-train generator: N pulses of high_len/low_len cycles with
// registered wave, edge strobes, busy and a completion pulse.
module pulse_train_gen #(
  parameter int LEN_W = 8,
  parameter int NUM_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_train_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [NUM_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [LEN_W-1:0] hi_q, lo_q;
  logic             done_nxt;
  logic             wave_q, rise_q, fall_q, busy_q, done_q;
  logic             wave_nxt, rise_nxt, fall_nxt, busy_nxt;
  logic             accept;

  // Phase counter holds remaining cycles minus one; a zero length behaves as 1.
  function automatic logic [LEN_W-1:0] phase_load(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and counter update
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    pulse_cnt_nxt = pulse_cnt;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_pulses == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt     = HIGH;
            phase_cnt_nxt = phase_load(bus.high_len);
            pulse_cnt_nxt = bus.num_pulses;
          end
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_nxt     = IDLE;
          phase_cnt_nxt = '0;
          pulse_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          state_nxt     = LOW;
          phase_cnt_nxt = phase_load(lo_q);
        end else begin
          phase_cnt_nxt = phase_cnt - LEN_W'(1);
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_nxt     = IDLE;
          phase_cnt_nxt = '0;
          pulse_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          if (pulse_cnt == NUM_W'(1)) begin
            state_nxt     = IDLE;
            pulse_cnt_nxt = '0;
            done_nxt      = 1'b1;
          end else begin
            state_nxt     = HIGH;
            phase_cnt_nxt = phase_load(hi_q);
            pulse_cnt_nxt = pulse_cnt - NUM_W'(1);
          end
        end else begin
          phase_cnt_nxt = phase_cnt - LEN_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        phase_cnt_nxt = '0;
        pulse_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: next-cycle values, registered below so strobes line up with wave
  always_comb begin
    wave_nxt = (state_nxt == HIGH);
    busy_nxt = (state_nxt != IDLE);
    rise_nxt = wave_nxt & ~wave_q;
    fall_nxt = ~wave_nxt & wave_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      pulse_cnt <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wave_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_cnt <= phase_cnt_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      if (accept) begin
        hi_q <= bus.high_len;
        lo_q <= bus.low_len;
      end
      wave_q <= wave_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.wave      = wave_q;
  assign bus.rise_edge = rise_q;
  assign bus.fall_edge = fall_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: each accepted start expands into a
// per-cycle expected trace that is popped and compared as the DUT runs.
module tb_pulse_train_gen;
  localparam int LEN_W = 8;
  localparam int NUM_W = 8;

  typedef struct packed {
    logic wave;
    logic rise;
    logic fall;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_train_gen_if #(.LEN_W(LEN_W), .NUM_W(NUM_W)) bus ();

  pulse_train_gen #(.LEN_W(LEN_W), .NUM_W(NUM_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic wave_d;
  int   rises, t_acc, acc_num, acc_dur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cfg(input int h, input int l, input int n);
    bus.high_len   = LEN_W'(h);
    bus.low_len    = LEN_W'(l);
    bus.num_pulses = NUM_W'(n);
  endtask

  // One clock: update the scoreboard from driven inputs, then compare next outputs
  task automatic step(input logic st, input logic ab);
    int h, l, n;
    exp_t e;
    bus.start = st;
    bus.abort = ab;
    if (cur.busy && ab) begin
      exp_q.delete();
      e = '0;
      e.fall = cur.wave;
      exp_q.push_back(e);
    end else if (!cur.busy && st) begin
      exp_q.delete();
      h = (bus.high_len == 0) ? 1 : int'(bus.high_len);
      l = (bus.low_len == 0) ? 1 : int'(bus.low_len);
      n = int'(bus.num_pulses);
      for (int p = 0; p < n; p++) begin
        for (int i = 0; i < h; i++) begin
          e = '0; e.wave = 1'b1; e.rise = (i == 0); e.busy = 1'b1;
          exp_q.push_back(e);
        end
        for (int i = 0; i < l; i++) begin
          e = '0; e.fall = (i == 0); e.busy = 1'b1;
          exp_q.push_back(e);
        end
      end
      e = '0; e.done = 1'b1;
      exp_q.push_back(e);
      t_acc   = cyc;
      acc_num = n;
      acc_dur = n * (h + l);
      rises   = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'('0);
    chk("outs", {27'd0, bus.wave, bus.rise_edge, bus.fall_edge, bus.busy, bus.done}, {27'd0, cur});
    chk("rise_rel", {31'd0, bus.rise_edge}, {31'd0, bus.wave & ~wave_d});
    chk("fall_rel", {31'd0, bus.fall_edge}, {31'd0, ~bus.wave & wave_d});
    chk("busy_and_done", {31'd0, bus.busy & bus.done}, 32'd0);
    if (bus.wave && !wave_d) rises++;
    if (bus.done) begin
      chk("burst_rises", rises, acc_num);
      chk("done_time", cyc - t_acc, 1 + acc_dur);
    end
    wave_d = bus.wave;
  endtask

  task automatic run_out(input bit jitter);
    int n = 0;
    while (cur.busy && n < 3000) begin
      if (jitter) begin
        cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
      end else begin
        step(1'b0, 1'b0);
      end
      n++;
    end
    chk("timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0);
    cur = '0;
    wave_d = 1'b0;
    rises = 0; t_acc = 0; acc_num = 0; acc_dur = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {27'd0, bus.wave, bus.rise_edge, bus.fall_edge, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // basic burst
    cfg(2, 3, 3); step(1'b1, 1'b0); run_out(1'b0);
    step(1'b0, 1'b0);
    // zero pulse count
    cfg(5, 5, 0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    // zero lengths behave as one
    cfg(0, 0, 4); step(1'b1, 1'b0); run_out(1'b0);
    // mid-burst start and config changes, then back-to-back start on done
    cfg(2, 3, 3); step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      step(i % 4 == 1, 1'b0);
    end
    run_out(1'b0);
    cfg(1, 2, 2); step(1'b1, 1'b0); run_out(1'b0);
    // abort in a high phase, restart two cycles later
    cfg(5, 5, 2); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    cfg(1, 1, 1); step(1'b1, 1'b0); run_out(1'b0);
    // abort alone in idle, then abort with start in idle
    step(1'b0, 1'b1);
    cfg(1, 2, 2); step(1'b1, 1'b1); run_out(1'b0);
    // abort in a low phase
    cfg(1, 4, 2); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
    // asynchronous reset mid-burst
    cfg(2, 3, 3); step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, bus.wave, bus.rise_edge, bus.fall_edge, bus.busy, bus.done}, 32'd0);
    exp_q.delete();
    cur = '0;
    wave_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b0);
    // extremes
    cfg(255, 255, 1); step(1'b1, 1'b0); run_out(1'b0);
    cfg(1, 1, 255); step(1'b1, 1'b0); run_out(1'b0);
    cfg(255, 0, 2); step(1'b1, 1'b0); run_out(1'b0);
    // random bursts with stray starts, aborts and config churn
    for (int b = 0; b < 25; b++) begin
      cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      step(1'b1, 1'b0);
      run_out(1'b1);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
